int_fu_arbiter: RTL and testbench

- Shares one non-pipelined 16-bit integer logic/arithmetic functional unit (OR/AND/XOR/SUB) among NREQ issue requesters.
- Round-robin arbitration; latches operands; sequences a fixed-latency execute phase; presents the tagged result on a writeback (result-bus) handshake.
- Sits between scoreboard issue logic and the integer FU; the FU itself is external and combinational.

---
 rtl/int_fu_arbiter_if.sv | 32 +++
 rtl/int_fu_arbiter.sv | 94 +++++++++
 tb/tb_int_fu_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/int_fu_arbiter_if.sv
// int_fu_arbiter_if: request, FU and writeback bundle between issue logic, arbiter and the shared FU
// Signals: req_valid/req_op/req_a/req_b/req_ready (issue side, flattened per requester),
// fu_op/fu_a/fu_b/fu_res (combinational FU), wb_valid/wb_tag/wb_data/wb_ready (result bus), busy.
// slave is the arbiter's view, master is the surrounding environment's view.
interface int_fu_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int TW = $clog2(NREQ);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [1:0]            fu_op;
  logic [WIDTH-1:0]      fu_a;
  logic [WIDTH-1:0]      fu_b;
  logic [WIDTH-1:0]      fu_res;
  logic                  wb_valid;
  logic [TW-1:0]         wb_tag;
  logic [WIDTH-1:0]      wb_data;
  logic                  wb_ready;
  logic                  busy;
  modport slave (
    input  req_valid, req_op, req_a, req_b, fu_res, wb_ready,
    output req_ready, fu_op, fu_a, fu_b, wb_valid, wb_tag, wb_data, busy
  );
  modport master (
    output req_valid, req_op, req_a, req_b, fu_res, wb_ready,
    input  req_ready, fu_op, fu_a, fu_b, wb_valid, wb_tag, wb_data, busy
  );
endinterface

// File: rtl/int_fu_arbiter.sv
// int_fu_arbiter: round-robin sharing of one non-pipelined integer FU among NREQ requesters
// Ports: clk, rst_n (synchronous, active low), bus (int_fu_arbiter_if.slave).
// Flow: IDLE grants one requester and latches its operands, EXEC holds them on the FU
// for LAT cycles, WB presents the tagged result until the result bus accepts it.
module int_fu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  int_fu_arbiter_if.slave bus
);
  localparam int TW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t           state, nxt;
  logic [TW-1:0]    rr_ptr, tag, gnt, idx;
  logic [TW:0]      sum;
  logic [1:0]       cnt;
  logic             hit;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       ops [NREQ];
  logic [WIDTH-1:0] as  [NREQ];
  logic [WIDTH-1:0] bs  [NREQ];
  genvar i;
  for (i = 0; i < NREQ; i++) begin : g_unpack
    assign ops[i] = bus.req_op[2*i +: 2];
    assign as[i]  = bus.req_a[WIDTH*i +: WIDTH];
    assign bs[i]  = bus.req_b[WIDTH*i +: WIDTH];
  end
  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    hit    = 1'b0;
    gnt    = '0;
    idx    = '0;
    sum    = '0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (TW+1)'(k);
      idx = sum >= (TW+1)'(NREQ) ? TW'(sum - (TW+1)'(NREQ)) : TW'(sum);
      if (bus.req_valid[idx]) begin
        hit    = 1'b1;
        gnt    = idx;
        sel_op = ops[idx];
        sel_a  = as[idx];
        sel_b  = bs[idx];
      end
    end
  end
  assign bus.req_ready = (state == IDLE && hit) ? NREQ'(1) << gnt : '0;
  assign bus.busy      = state != IDLE;
  always_comb begin
    nxt = state;
    if (state == IDLE && hit) nxt = EXEC;
    if (state == EXEC && cnt == '0) nxt = WB;
    if (state == WB && bus.wb_ready) nxt = IDLE;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  // fu_* only reload on a grant, so they keep the last operands outside EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      cnt          <= '0;
      tag          <= '0;
      bus.fu_op    <= '0;
      bus.fu_a     <= '0;
      bus.fu_b     <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_tag   <= '0;
      bus.wb_data  <= '0;
    end else begin
      if (state == IDLE && hit) begin
        bus.fu_op <= sel_op;
        bus.fu_a  <= sel_a;
        bus.fu_b  <= sel_b;
        tag       <= gnt;
        rr_ptr    <= gnt == TW'(NREQ - 1) ? '0 : gnt + 1'b1;
        cnt       <= 2'(LAT - 1);
      end
      if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          bus.wb_data  <= bus.fu_res;
          bus.wb_tag   <= tag;
          bus.wb_valid <= 1'b1;
        end
      end
      if (state == WB && bus.wb_ready) bus.wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_int_fu_arbiter.sv
// tb_int_fu_arbiter: scoreboard bench for int_fu_arbiter with a behavioural FU
module tb_int_fu_arbiter;
  localparam int NREQ = 4, WIDTH = 16, LAT = 2;
  typedef struct {int tag; logic [15:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] hold = '0;
  int nchk = 0, nerr = 0, base = 0;
  exp_t exp_q[$];
  exp_t e;
  int grants[$];
  int order3[5] = '{0, 2, 0, 1, 2};

  int_fu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();
  int_fu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return a - b;
    endcase
  endfunction

  assign bus.fu_res = alu(bus.fu_op, bus.fu_a, bus.fu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else begin
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (bus.req_ready[i]) begin
            grants.push_back(i);
            exp_q.push_back('{i, alu(bus.req_op[2*i +: 2], bus.req_a[16*i +: 16], bus.req_b[16*i +: 16])});
          end
        check("onehot", 32'($countones(bus.req_ready)), 1);
      end
      if (bus.wb_valid && bus.wb_ready) begin
        if (exp_q.size() == 0) check("wb_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wb_tag", 32'(bus.wb_tag), e.tag);
          check("wb_data", 32'(bus.wb_data), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~(g & ~hold);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req_op[2*i +: 2]  = op;
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  function automatic bit pending();
    return bus.busy || bus.wb_valid || bus.req_valid != '0 || exp_q.size() != 0;
  endfunction

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && pending(); n++) tick();
    check("drain", 32'(pending()), 0);
  endtask

  task automatic wait_wb(input int budget);
    for (int n = 0; n < budget && !bus.wb_valid; n++) tick();
    check("wb_seen", 32'(bus.wb_valid), 1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    for (int k = 0; k < budget && grants.size() < n; k++) tick();
    check("grant_count", grants.size() >= n, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold = '0;
    bus.req_valid = '0;
    bus.wb_ready = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_wb_valid", 32'(bus.wb_valid), 0);
    check("rst_fu_a", 32'(bus.fu_a), 0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.wb_ready = 1'b1;
    do_reset();
    // basic OR with cycle-exact timing
    set_req(0, 2'd0, 16'd8, 16'd6);
    #2;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_fu_a_c1", 32'(bus.fu_a), 8);
    check("t1_fu_b_c1", 32'(bus.fu_b), 6);
    tick();
    check("t1_fu_a_c2", 32'(bus.fu_a), 8);
    check("t1_fu_b_c2", 32'(bus.fu_b), 6);
    tick();
    check("t1_wb_valid", 32'(bus.wb_valid), 1);
    check("t1_wb_tag", 32'(bus.wb_tag), 0);
    check("t1_wb_data", 32'(bus.wb_data), 14);
    tick();
    check("t1_idle", 32'(bus.busy), 0);
    wait_drain(20);
    // four simultaneous requesters from a fresh pointer
    do_reset();
    base = grants.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 16'd12, 16'd10);
    wait_drain(60);
    check("t2_count", grants.size() - base, 4);
    if (grants.size() - base >= 4)
      for (int k = 0; k < 4; k++) check("t2_order", grants[base+k], k);
    check("t2_rr_ptr", 32'(dut.rr_ptr), 0);
    // fairness: 0 and 2 held, 1 joins late
    base = grants.size();
    hold = 4'b0101;
    set_req(0, 2'd2, 16'h1234, 16'h00FF);
    set_req(2, 2'd1, 16'h5A5A, 16'h0FF0);
    wait_grants(base + 3, 40);
    set_req(1, 2'd3, 16'd100, 16'd1);
    wait_grants(base + 5, 40);
    hold = '0;
    bus.req_valid = '0;
    wait_drain(40);
    if (grants.size() - base >= 5)
      for (int k = 0; k < 5; k++) check("t3_order", grants[base+k], order3[k]);
    // writeback backpressure
    bus.wb_ready = 1'b0;
    set_req(3, 2'd2, 16'h00F0, 16'h0FF0);
    wait_wb(10);
    set_req(1, 2'd0, 16'h0001, 16'h0002);
    repeat (5) begin
      #1;
      check("t4_wb_valid", 32'(bus.wb_valid), 1);
      check("t4_wb_data", 32'(bus.wb_data), 32'h0F00);
      check("t4_wb_tag", 32'(bus.wb_tag), 3);
      check("t4_no_grant", 32'(bus.req_ready), 0);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    check("t4_hs_no_grant", 32'(bus.req_ready), 0);
    tick();
    #1;
    check("t4_resume", 32'(bus.req_ready), 32'h2);
    wait_drain(20);
    // SUB wraps modulo 2^16
    set_req(2, 2'd3, 16'd6, 16'd8);
    wait_wb(10);
    check("t5_wrap", 32'(bus.wb_data), 32'hFFFE);
    check("t5_tag", 32'(bus.wb_tag), 2);
    wait_drain(20);
    // reset during the second EXEC cycle
    set_req(1, 2'd1, 16'hFFFF, 16'h1111);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_wb_valid", 32'(bus.wb_valid), 0);
    check("t6_rr_ptr", 32'(dut.rr_ptr), 0);
    check("t6_fu_a", 32'(bus.fu_a), 0);
    check("t6_fu_b", 32'(bus.fu_b), 0);
    check("t6_fu_op", 32'(bus.fu_op), 0);
    check("t6_wb_data", 32'(bus.wb_data), 0);
    check("t6_wb_tag", 32'(bus.wb_tag), 0);
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      check("t6_no_wb", 32'(bus.wb_valid), 0);
    end
    set_req(1, 2'd1, 16'hABCD, 16'h0FF0);
    wait_wb(10);
    check("t6_after", 32'(bus.wb_data), 32'h0BC0);
    wait_drain(20);
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
